// File: rtl/adder_pkg.sv
// Shared sizing constants and helpers for the ripple-carry adder and the
// multiplier datapath that instantiates it.
package adder_pkg;

    localparam int ADDER_DEFAULT_WIDTH = 4;

    // Width of a full, non-wrapping sum of two w-bit unsigned operands.
    function automatic int adder_sum_width(input int w);
        return w + 1;
    endfunction

endpackage

// File: rtl/adder_full_adder.sv
// One-bit full-adder cell; the ripple chain in adder is built from these.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p_s;

    assign p_s  = a ^ b;
    assign s    = p_s ^ cin;
    assign cout = (a & b) | (cin & p_s);

endmodule

// File: rtl/adder.sv
// Unsigned ripple-carry adder with a combinational (WIDTH+1)-bit sum and a
// registered copy qualified by a one-cycle valid flag.
module adder
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_DEFAULT_WIDTH,
    localparam int SUM_W = adder_sum_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             en,
    output logic [SUM_W-1:0] saida,
    output logic [SUM_W-1:0] saida_q,
    output logic             valid_q,
    output logic             carry_q
);

    logic [WIDTH:0]   carry_s;
    logic [WIDTH-1:0] sum_s;
    logic [SUM_W-1:0] saida_r;
    logic             carry_r;
    logic             valid_r;

    // Kept structural so timing analysis sees every ripple cell on the path.
    assign carry_s[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder u_fa (
            .a    (A[i]),
            .b    (B[i]),
            .cin  (carry_s[i]),
            .s    (sum_s[i]),
            .cout (carry_s[i+1])
        );
    end

    assign saida = {carry_s[WIDTH], sum_s};

    // Capture register: reset wins over en; valid drops on any idle cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            saida_r <= {SUM_W{1'b0}};
            carry_r <= 1'b0;
            valid_r <= 1'b0;
        end else if (en) begin
            saida_r <= saida;
            carry_r <= carry_s[WIDTH];
            valid_r <= 1'b1;
        end else begin
            valid_r <= 1'b0;
        end
    end

    assign saida_q = saida_r;
    assign carry_q = carry_r;
    assign valid_q = valid_r;

endmodule

// File: tb/tb_adder.sv
// Self-checking bench for adder at WIDTH=1, 4 and 8 against a plain
// arithmetic reference of the sum and of the capture register.
module tb_adder;

    logic       clk;
    logic       rst;
    logic       en;
    logic       a1, b1;
    logic [3:0] a4, b4;
    logic [7:0] a8, b8;
    logic [1:0] s1, q1;
    logic [4:0] s4, q4;
    logic [8:0] s8, q8;
    logic       v1, v4, v8, c1, c4, c8;

    int total;
    int bad;

    // reference register state for the 4- and 8-bit instances
    int  m4_q, m8_q;
    bit  m_v;

    adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .A(a1), .B(b1), .en(en),
        .saida(s1), .saida_q(q1), .valid_q(v1), .carry_q(c1)
    );

    adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .A(a4), .B(b4), .en(en),
        .saida(s4), .saida_q(q4), .valid_q(v4), .carry_q(c4)
    );

    adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .A(a8), .B(b8), .en(en),
        .saida(s8), .saida_q(q8), .valid_q(v8), .carry_q(c8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        en    = 1'b0;
        a1 = 1'b0; b1 = 1'b0;
        a4 = 4'd0; b4 = 4'd0;
        a8 = 8'd0; b8 = 8'd0;
        #2;
        check("reset_saida_q", longint'(q4), 0);
        check("reset_carry_q", longint'(c4), 0);
        check("reset_valid_q", longint'(v4), 0);
        @(negedge clk);
        rst = 1'b0;

        // combinational directed cases, no clock edge needed
        a4 = 4'd10; b4 = 4'd5; #1;
        check("comb_10_5", longint'(s4), 15);
        check("comb_10_5_carry", longint'(s4[4]), 0);
        a4 = 4'd8; #1;
        check("comb_8_5", longint'(s4), 13);
        b4 = 4'd6; #1;
        check("comb_8_6", longint'(s4), 14);
        a4 = 4'd9; b4 = 4'd10; #1;
        check("comb_9_10", longint'(s4), 19);
        check("comb_9_10_carry", longint'(s4[4]), 1);
        a4 = 4'd15; b4 = 4'd15; #1;
        check("comb_max", longint'(s4), 30);
        a4 = 4'd0; b4 = 4'd0; #1;
        check("comb_zero", longint'(s4), 0);

        // registered capture then hold
        @(negedge clk);
        a4 = 4'd9; b4 = 4'd10; en = 1'b1;
        tick();
        check("cap_saida_q", longint'(q4), 19);
        check("cap_carry_q", longint'(c4), 1);
        check("cap_valid_q", longint'(v4), 1);
        @(negedge clk);
        en = 1'b0; a4 = 4'd1; b4 = 4'd2;
        tick();
        check("hold_valid_q", longint'(v4), 0);
        check("hold_saida_q", longint'(q4), 19);
        check("hold_carry_q", longint'(c4), 1);

        // async reset mid-cycle while valid is high
        @(negedge clk);
        a4 = 4'd9; b4 = 4'd10; en = 1'b1;
        tick();
        check("pre_rst_valid_q", longint'(v4), 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_saida_q", longint'(q4), 0);
        check("async_rst_carry_q", longint'(c4), 0);
        check("async_rst_valid_q", longint'(v4), 0);
        a4 = 4'd7; b4 = 4'd12; #1;
        check("saida_during_rst", longint'(s4), 19);
        // reset and en high together at an edge: reset wins
        tick();
        check("rst_beats_en_valid", longint'(v4), 0);
        check("rst_beats_en_saida_q", longint'(q4), 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("post_rst_capture", longint'(q4), 19);
        check("post_rst_valid", longint'(v4), 1);
        @(negedge clk);
        en = 1'b0;

        // exhaustive combinational sweeps
        for (int ai = 0; ai < 2; ai++) begin
            for (int bi = 0; bi < 2; bi++) begin
                a1 = 1'(ai); b1 = 1'(bi); #1;
                check("sweep_w1", longint'(s1), longint'(ai + bi));
            end
        end
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                a4 = 4'(ai); b4 = 4'(bi); #1;
                check("sweep_w4", longint'(s4), longint'(ai + bi));
            end
        end
        for (int ai = 0; ai < 256; ai++) begin
            for (int bi = 0; bi < 256; bi++) begin
                a8 = 8'(ai); b8 = 8'(bi); #1;
                check("sweep_w8", longint'(s8), longint'(ai + bi));
            end
        end

        // randomized registered traffic against the reference model
        @(negedge clk);
        en = 1'b1; a4 = 4'd3; b4 = 4'd4; a8 = 8'd200; b8 = 8'd100;
        tick();
        m4_q = 7; m8_q = 300; m_v = 1'b1;
        check("rnd_seed_q4", longint'(q4), longint'(m4_q));
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            a4 = 4'($urandom_range(15, 0));
            b4 = 4'($urandom_range(15, 0));
            a8 = 8'($urandom_range(255, 0));
            b8 = 8'($urandom_range(255, 0));
            en = ($urandom_range(3, 0) != 0);
            if (en) begin
                m4_q = int'(a4) + int'(b4);
                m8_q = int'(a8) + int'(b8);
                m_v  = 1'b1;
            end else begin
                m_v  = 1'b0;
            end
            tick();
            check("rnd_q4", longint'(q4), longint'(m4_q));
            check("rnd_c4", longint'(c4), longint'(m4_q >= 16));
            check("rnd_v4", longint'(v4), longint'(m_v));
            check("rnd_q8", longint'(q8), longint'(m8_q));
            check("rnd_c8", longint'(c8), longint'(m8_q >= 256));
            check("rnd_v8", longint'(v8), longint'(m_v));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adder.md
# adder

Unsigned ripple-carry adder for the multiplier datapath. Two WIDTH-bit operands go in, and a (WIDTH+1)-bit sum comes out with the carry as its MSB. The combinational sum feeds the multiplier's partial-product accumulation directly. A registered copy with a valid flag is provided for pipelined use.

## Interface
- `WIDTH`, default 4: operand width in bits; legal range is 1 to 32.
- `clk`, input, 1 bit: single clock; all registered state updates on the rising edge.
- `rst`, input, 1 bit: asynchronous, active-high reset.
- `A`, input, WIDTH bits: operand A, unsigned.
- `B`, input, WIDTH bits: operand B, unsigned.
- `en`, input, 1 bit: when high, the current sum is captured into the output register.
- `saida`, output, WIDTH+1 bits: combinational sum A+B; bit WIDTH is the carry-out.
- `saida_q`, output, WIDTH+1 bits: registered sum.
- `valid_q`, output, 1 bit: high when `saida_q` holds a sum captured in the previous cycle.
- `carry_q`, output, 1 bit: registered carry-out, equal to `saida_q[WIDTH]`.

## Operation
- `saida = {1'b0,A} + {1'b0,B}`. The sum is full width and never wraps.
- Maximum value is 2*(2^WIDTH-1). For WIDTH=4 that is 15+15=30.
- The sum is built as a ripple chain of WIDTH full-adder cells.
  - Cell 0 has carry-in tied to 0.
  - The carry-out of cell WIDTH-1 drives `saida[WIDTH]`.
- Each full-adder cell computes:
  - `s = a ^ b ^ cin`
  - `cout = (a & b) | (cin & (a ^ b))`
- `saida` depends only on A and B. It is unaffected by `clk`, `rst` and `en`.
- Registered path:
  - On a rising edge with `en`=1: `saida_q <= saida`, `carry_q <= saida[WIDTH]`, `valid_q <= 1`.
  - On a rising edge with `en`=0: `valid_q <= 0`; `saida_q` and `carry_q` hold their values.
- Operands are unsigned only. There is no overflow flag; the carry bit is part of the result.

## Timing
- Combinational path: `saida` is valid one propagation delay after A or B changes. There is no cycle latency.
- Registered path: latency is 1 cycle from `en` sampled high to `valid_q`/`saida_q` updating.
- Reset values: `saida_q`=0, `carry_q`=0, `valid_q`=0.
- Asserting `rst` clears all three immediately, without waiting for a clock edge.
- Reset during operation: a capture pending in the same cycle is discarded.
  - After `rst` deasserts, the first edge with `en`=1 captures normally.
- Reset and `en` both high at a clock edge: reset wins.
- Back-to-back `en`: a new sum is captured every cycle and `valid_q` stays high.
- `saida` continues to follow A+B during reset.

## Structure
- Sub-module `full_adder`: one-bit cell with ports `a`, `b`, `cin`, `s`, `cout`. It is instantiated WIDTH times in a generate loop.
- Shared package `adder_pkg`:
  - constant `ADDER_DEFAULT_WIDTH = 4`
  - function `adder_sum_width(w) = w+1`
  - The multiplier uses both for sizing.
- Use no behavioural `+` operator in the combinational sum; the chain is structural so the multiplier's critical-path analysis sees the ripple cells.

## Test plan
- WIDTH=4, A=10, B=5 -> `saida`=15 within 1 ns, carry bit 0.
- A changed to 8 with B=5 -> `saida`=13. Then B changed to 6 -> `saida`=14. Both settle with no clock edge.
- A=9, B=10 -> `saida`=19 (5'b10011, carry=1). Extremes:
  - A=15, B=15 -> 30.
  - A=0, B=0 -> 0.
- Registered capture: `en`=1 at one edge with A=9, B=10 -> next cycle `saida_q`=19, `carry_q`=1, `valid_q`=1. Then `en`=0 -> `valid_q`=0 and `saida_q` holds 19.
- Asynchronous reset: assert `rst` mid-cycle while `valid_q`=1 -> `saida_q`/`carry_q`/`valid_q` go to 0 before the next edge. Combinational `saida` is unaffected.
- Exhaustive sweep for WIDTH=4: check all 256 A/B pairs against `A+B`. Repeat with WIDTH=1 (0..2) and WIDTH=8 (255+255=510).
